// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 serial transmitter with a small TX FIFO and baud divisor.
// Optional macro UART_TX_PARITY_EN adds a parity bit between data and stop (CTRL bit1 = odd).
`default_nettype none

module mmio_uart_tx #(
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  a,
  input  logic        we,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        tx,
  output logic        irq
);

  localparam int c_aw = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int c_cw = $clog2(FIFO_DEPTH + 1);
  localparam logic [c_cw-1:0] c_full    = c_cw'(FIFO_DEPTH);
  localparam logic [c_aw-1:0] c_ptr_one = c_aw'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3
`ifdef UART_TX_PARITY_EN
    , S_PARITY = 3'd4
`endif
  } state_t;

  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [c_aw-1:0] r_wptr;
  logic [c_aw-1:0] r_rptr;
  logic [c_cw-1:0] r_count;
  logic            r_ovf;
  logic [15:0]     r_div;
  logic            r_en;
  state_t          r_state;
  logic [15:0]     r_timer;
  logic [15:0]     r_div_lat;
  logic [7:0]      r_shift;
  logic [2:0]      r_bitcnt;
  logic            r_tx;
`ifdef UART_TX_PARITY_EN
  logic            r_odd;
  logic            r_par;
`endif

  logic        w_push;
  logic        w_push_ok;
  logic        w_pop;
  logic        w_empty;
  logic        w_full;
  logic        w_busy;
  logic        w_last;
  logic [7:0]  w_head;
  logic [31:0] w_cnt_ext;
  logic        w_unused;

  assign w_push    = we && (a == 2'd0);
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == c_full);
  assign w_busy    = (r_state != S_IDLE);
  assign w_last    = (r_timer == 16'd0);
  assign w_head    = r_mem[r_rptr];
  // A pop frees a slot on the same edge, so a push into a full FIFO still lands.
  assign w_pop     = r_en && !w_empty &&
                     ((r_state == S_IDLE) || ((r_state == S_STOP) && w_last));
  assign w_push_ok = w_push && (!w_full || w_pop);
  assign w_cnt_ext = 32'(r_count);
  assign w_unused  = ^{wd[31:16], w_cnt_ext[31:4]};

  assign tx  = r_tx;
  assign irq = w_empty && !w_busy;

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wptr] <= wd[7:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + c_ptr_one;
      if (w_pop)     r_rptr <= r_rptr + c_ptr_one;
      r_count <= r_count + {{(c_cw-1){1'b0}}, w_push_ok} - {{(c_cw-1){1'b0}}, w_pop};
      if (w_push && w_full && !w_pop)
        r_ovf <= 1'b1;
      else if (we && (a == 2'd1) && wd[3])
        r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div <= DEFAULT_DIV;
      r_en  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_odd <= 1'b0;
`endif
    end else if (we) begin
      if (a == 2'd2) r_div <= wd[15:0];
      if (a == 2'd3) begin
        r_en <= wd[0];
`ifdef UART_TX_PARITY_EN
        r_odd <= wd[1];
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_timer   <= '0;
      r_div_lat <= '0;
      r_shift   <= '0;
      r_bitcnt  <= '0;
      r_tx      <= 1'b1;
`ifdef UART_TX_PARITY_EN
      r_par     <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_tx <= 1'b1;
          if (w_pop) begin
            r_shift   <= w_head;
            r_div_lat <= r_div;
            r_timer   <= r_div;
            r_tx      <= 1'b0;
            r_state   <= S_START;
`ifdef UART_TX_PARITY_EN
            r_par     <= (^w_head) ^ r_odd;
`endif
          end
        end
        S_START: begin
          if (w_last) begin
            r_state  <= S_DATA;
            r_tx     <= r_shift[0];
            r_timer  <= r_div_lat;
            r_bitcnt <= 3'd0;
          end else begin
            r_timer <= r_timer - 16'd1;
          end
        end
        S_DATA: begin
          if (w_last) begin
            r_timer <= r_div_lat;
            if (r_bitcnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              r_state <= S_PARITY;
              r_tx    <= r_par;
`else
              r_state <= S_STOP;
              r_tx    <= 1'b1;
`endif
            end else begin
              r_bitcnt <= r_bitcnt + 3'd1;
              r_shift  <= {1'b0, r_shift[7:1]};
              r_tx     <= r_shift[1];
            end
          end else begin
            r_timer <= r_timer - 16'd1;
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (w_last) begin
            r_state <= S_STOP;
            r_tx    <= 1'b1;
            r_timer <= r_div_lat;
          end else begin
            r_timer <= r_timer - 16'd1;
          end
        end
`endif
        S_STOP: begin
          if (w_last) begin
            // Back-to-back frames: the next start bit follows the stop bit directly.
            if (w_pop) begin
              r_shift   <= w_head;
              r_div_lat <= r_div;
              r_timer   <= r_div;
              r_tx      <= 1'b0;
              r_state   <= S_START;
`ifdef UART_TX_PARITY_EN
              r_par     <= (^w_head) ^ r_odd;
`endif
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_timer <= r_timer - 16'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    rd = '0;
    case (a)
      2'd1: rd[7:0] = {w_cnt_ext[3:0], r_ovf, w_busy, w_full, w_empty};
      2'd2: rd[15:0] = r_div;
      2'd3: begin
        rd[0] = r_en;
`ifdef UART_TX_PARITY_EN
        rd[1] = r_odd;
`endif
      end
      default: rd = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: directed plus randomized checks of mmio_uart_tx against a bit-list frame model.
`default_nettype none

module tb_mmio_uart_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  a;
  logic        we;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        tx;
  logic        irq;

  int   checks   = 0;
  int   failures = 0;
  logic odd_sel  = 1'b0;

  always #5 clk = ~clk;

  mmio_uart_tx dut (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .we  (we),
    .wd  (wd),
    .rd  (rd),
    .tx  (tx),
    .irq (irq)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] addr, input logic [31:0] data);
    @(negedge clk);
    a  = addr;
    wd = data;
    we = 1'b1;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic rdchk(input logic [1:0] addr, input logic [31:0] exp, input string tag);
    a = addr;
    #1;
    chk(tag, rd, exp);
  endtask

  // Expected line levels of one frame, each held div+1 clocks, from the first start-bit cycle.
  task automatic expect_frame(input logic [7:0] b, input int div, input string tag);
    logic bits[$];
    bits = {};
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
    bits.push_back((^b) ^ odd_sel);
`endif
    bits.push_back(1'b1);
    foreach (bits[k]) begin
      for (int c = 0; c <= div; c++) begin
        @(negedge clk);
        chk($sformatf("%s_bit%0d_c%0d", tag, k, c), {31'd0, tx}, {31'd0, bits[k]});
        if (k == 0 && c == 0) chk({tag, "_irq_busy"}, {31'd0, irq}, 32'd0);
      end
    end
  endtask

  function automatic logic [31:0] status_of(input int cnt, input logic ovf, input int depth);
    return (cnt << 4) | (ovf ? 32'h8 : 32'h0) | ((cnt == depth) ? 32'h2 : 32'h0) |
           ((cnt == 0) ? 32'h1 : 32'h0);
  endfunction

  initial begin
    logic [7:0] q[$];
    logic       ovf;
    logic [7:0] b;
    logic [7:0] b2;
    int         d;

    rst = 1'b0; a = 2'd0; we = 1'b0; wd = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rdchk(2'd1, 32'h1, "reset_status");
    rdchk(2'd2, 32'd433, "reset_div");
    rdchk(2'd3, 32'd0, "reset_ctrl");
    rdchk(2'd0, 32'd0, "txdata_reads_zero");
    chk("reset_tx", {31'd0, tx}, 32'd1);
    chk("reset_irq", {31'd0, irq}, 32'd1);

    wr(2'd2, 32'd3);
    wr(2'd3, 32'd1);
    wr(2'd0, 32'hA5);
    expect_frame(8'hA5, 3, "a5");
    @(negedge clk);
    chk("a5_irq_after", {31'd0, irq}, 32'd1);
    rdchk(2'd1, 32'h1, "a5_status_after");

    wr(2'd3, 32'd3);
`ifdef UART_TX_PARITY_EN
    rdchk(2'd3, 32'd3, "ctrl_bit1_rw");
`else
    rdchk(2'd3, 32'd1, "ctrl_bit1_ignored");
`endif
    wr(2'd3, 32'd1);

    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom);
      d = int'($urandom_range(0, 4));
      wr(2'd2, 32'(d));
      wr(2'd0, {24'd0, b});
      expect_frame(b, d, $sformatf("rnd%0d", i));
      @(negedge clk);
      chk($sformatf("rnd%0d_irq_after", i), {31'd0, irq}, 32'd1);
    end

    wr(2'd3, 32'd0);
    wr(2'd2, 32'd0);
    q = {}; ovf = 1'b0;
    for (int i = 0; i < 5; i++) begin
      b = 8'($urandom);
      wr(2'd0, {24'd0, b});
      if (q.size() < 4) q.push_back(b); else ovf = 1'b1;
      rdchk(2'd1, status_of(q.size(), ovf, 4), $sformatf("fill%0d_status", i));
    end
    wr(2'd1, 32'h8);
    ovf = 1'b0;
    rdchk(2'd1, status_of(q.size(), ovf, 4), "ovf_clear_status");

    wr(2'd3, 32'd1);
    for (int i = 0; i < 4; i++) expect_frame(q.pop_front(), 0, $sformatf("b2b%0d", i));
    @(negedge clk);
    chk("b2b_irq_after", {31'd0, irq}, 32'd1);
    rdchk(2'd1, 32'h1, "b2b_status_after");

    // Divisor written mid-frame must only affect the following frame.
    wr(2'd3, 32'd0);
    wr(2'd2, 32'd1);
    b = 8'($urandom); b2 = 8'($urandom);
    wr(2'd0, {24'd0, b});
    wr(2'd0, {24'd0, b2});
    wr(2'd3, 32'd1);
    fork
      begin
        expect_frame(b, 1, "lat_a");
        expect_frame(b2, 3, "lat_b");
      end
      begin
        repeat (3) @(negedge clk);
        wr(2'd2, 32'd3);
      end
    join
    @(negedge clk);
    chk("lat_irq_after", {31'd0, irq}, 32'd1);

    // Clearing enable mid-frame finishes the frame and keeps the rest queued.
    wr(2'd3, 32'd0);
    wr(2'd2, 32'd0);
    b = 8'($urandom); b2 = 8'($urandom);
    wr(2'd0, {24'd0, b});
    wr(2'd0, {24'd0, b2});
    wr(2'd3, 32'd1);
    fork
      expect_frame(b, 0, "dis_a");
      begin
        repeat (2) @(negedge clk);
        wr(2'd3, 32'd0);
      end
    join
    repeat (3) begin
      @(negedge clk);
      chk("dis_idle_tx", {31'd0, tx}, 32'd1);
    end
    rdchk(2'd1, status_of(1, 1'b0, 4), "dis_status_retained");
    wr(2'd3, 32'd1);
    expect_frame(b2, 0, "dis_b");

    wr(2'd2, 32'd3);
    wr(2'd0, 32'h00);
    repeat (13) @(negedge clk);
    chk("mid_data_tx_low", {31'd0, tx}, 32'd0);
    #2;
    rst = 1'b0;
    #1;
    chk("async_reset_tx", {31'd0, tx}, 32'd1);
    chk("async_reset_irq", {31'd0, irq}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rdchk(2'd1, 32'h1, "post_reset_status");
    rdchk(2'd3, 32'd0, "post_reset_ctrl");
    rdchk(2'd2, 32'd433, "post_reset_div");

`ifdef UART_TX_PARITY_EN
    wr(2'd2, 32'd0);
    wr(2'd3, 32'd1);
    odd_sel = 1'b0;
    wr(2'd0, 32'h07);
    expect_frame(8'h07, 0, "par_even");
    @(negedge clk);
    chk("par_even_irq", {31'd0, irq}, 32'd1);
    wr(2'd3, 32'd3);
    odd_sel = 1'b1;
    wr(2'd0, 32'h07);
    expect_frame(8'h07, 0, "par_odd");
    @(negedge clk);
    chk("par_odd_irq", {31'd0, irq}, 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
